sadc_sample_fifo: RTL and testbench

SADC_SAMPLE_FIFO -- requirements
Module: sadc_sample_fifo

---
 rtl/sadc_sample_fifo.sv | 203 ++++++++++++++++++++
 tb/tb_sadc_sample_fifo.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sadc_sample_fifo.sv
// rtl/sadc_sample_fifo.sv - APB-mapped sample FIFO fed by an asynchronous ADC strobe
//
// Purpose: synchronises the ADC sample strobe into the pclk domain, buffers
// captured 12-bit samples in a DEPTH-entry FIFO and exposes control, status
// and a pop-on-read data port over APB, with a level interrupt.
//
// Ports:
//   pclk, presetn              - clock and asynchronous active-low reset
//   psel, penable, pwrite      - APB controls (single-cycle access accepted)
//   paddr[5:2], pwdata[31:0]   - word address and write data
//   prdata[31:0], pready       - read data, always ready
//   fr_sadc_clk, fr_sadc_data  - asynchronous ADC strobe and 12-bit result
//   sadc_int                   - registered level interrupt
//
// Configuration macro: SADC_FIFO_AVG_EN enables 4-sample averaging (CTRL[2]).

module sadc_sample_fifo #(
  parameter int DEPTH = 16
) (
  input  logic        pclk,
  input  logic        presetn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [5:2]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  input  logic        fr_sadc_clk,
  input  logic [11:0] fr_sadc_data,
  output logic        sadc_int
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = 7;

  // Strobe and data synchronisers
  logic        s0, s1, s2;
  logic [11:0] d0, d1;
  logic        edge_det;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      s0 <= 1'b0;
      s1 <= 1'b0;
      s2 <= 1'b0;
      d0 <= '0;
      d1 <= '0;
    end else begin
      s0 <= fr_sadc_clk;
      s1 <= s0;
      s2 <= s1;
      d0 <= fr_sadc_data;
      d1 <= d0;
    end
  end

  // d1 lines up with s1, so it holds the sample belonging to this edge
  assign edge_det = s1 & ~s2;

  // APB decode
  logic wr_en, rd_en, ctrl_wr, stat_wr, data_rd, flush;

  assign pready  = 1'b1;
  assign wr_en   = psel & penable & pwrite;
  assign rd_en   = psel & penable & ~pwrite;
  assign ctrl_wr = wr_en & (paddr == 4'h0);
  assign stat_wr = wr_en & (paddr == 4'h1);
  assign data_rd = rd_en & (paddr == 4'h2);
  assign flush   = ctrl_wr & pwdata[1];

  // Control register
  logic       en, thr_ie, ovf_ie, avg_en;
  logic [3:0] thresh;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      en     <= 1'b0;
      thresh <= '0;
      thr_ie <= 1'b0;
      ovf_ie <= 1'b0;
    end else if (ctrl_wr) begin
      en     <= pwdata[0];
      thresh <= pwdata[7:4];
      thr_ie <= pwdata[8];
      ovf_ie <= pwdata[9];
    end
  end

  logic        cap;
  logic        push_req;
  logic [11:0] push_data;

  assign cap = edge_det & en;

`ifdef SADC_FIFO_AVG_EN
  logic [13:0] acc;
  logic [13:0] sum;
  logic [1:0]  acnt;
  logic        avg_clr;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)     avg_en <= 1'b0;
    else if (ctrl_wr) avg_en <= pwdata[2];
  end

  // Any change of averaging mode or loss of enable restarts the group of four
  assign avg_clr   = flush | ~en | (ctrl_wr & (pwdata[2] != avg_en));
  assign sum       = acc + {2'b00, d1};
  assign push_req  = cap & (~avg_en | (acnt == 2'd3));
  assign push_data = avg_en ? sum[13:2] : d1;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      acc  <= '0;
      acnt <= '0;
    end else if (avg_clr) begin
      acc  <= '0;
      acnt <= '0;
    end else if (cap && avg_en) begin
      if (acnt == 2'd3) begin
        acc  <= '0;
        acnt <= '0;
      end else begin
        acc  <= sum;
        acnt <= acnt + 2'd1;
      end
    end
  end
`else
  assign avg_en    = 1'b0;
  assign push_req  = cap;
  assign push_data = d1;
`endif

  // FIFO storage and pointers
  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [LW-1:0] level;
  logic          empty, full, pop, push_ok, ovf_set;
  logic          ovf, thr_hit;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign pop     = data_rd & ~empty;
  // A pop in the same cycle frees the slot a full FIFO would otherwise lack
  assign push_ok = push_req & ~flush & (~full | pop);
  assign ovf_set = push_req & ~flush & full & ~pop;
  assign thr_hit = (thresh != 4'd0) & (level >= {3'b000, thresh});

  always_ff @(posedge pclk) begin
    if (push_ok) mem[wptr] <= push_data;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else if (flush) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (push_ok) wptr <= wptr + AW'(1);
      if (pop)     rptr <= rptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Overflow flag: hardware set takes priority over the W1C clear
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn)                    ovf <= 1'b0;
    else if (ovf_set)                ovf <= 1'b1;
    else if (stat_wr && pwdata[10])  ovf <= 1'b0;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) sadc_int <= 1'b0;
    else          sadc_int <= (thr_ie & thr_hit) | (ovf_ie & ovf);
  end

  // Read mux
  always_comb begin
    prdata = '0;
    if (presetn && rd_en) begin
      case (paddr)
        4'h0: prdata = {22'b0, ovf_ie, thr_ie, thresh, 1'b0, avg_en, 1'b0, en};
        4'h1: prdata = {20'b0, thr_hit, ovf, full, empty, 1'b0, level};
        4'h2: if (!empty) prdata = {1'b1, 19'b0, mem[rptr]};
        default: prdata = '0;
      endcase
    end
  end

  logic unused_ok;
  assign unused_ok = ^pwdata;

endmodule

// File: tb/tb_sadc_sample_fifo.sv
// tb/tb_sadc_sample_fifo.sv - randomized scoreboard bench for sadc_sample_fifo

module tb_sadc_sample_fifo;

  localparam int DEPTH = 16;

  logic        pclk = 1'b0;
  logic        presetn = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [5:2]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready;
  logic        fr_sadc_clk = 1'b0;
  logic [11:0] fr_sadc_data = '0;
  logic        sadc_int;

  sadc_sample_fifo #(.DEPTH(DEPTH)) dut (
    .pclk(pclk), .presetn(presetn),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata),
    .prdata(prdata), .pready(pready),
    .fr_sadc_clk(fr_sadc_clk), .fr_sadc_data(fr_sadc_data),
    .sadc_int(sadc_int)
  );

  always #5 pclk = ~pclk;

  int checks = 0;
  int errors = 0;

  // Scoreboard of expected prdata values, one per read access
  logic [31:0] exp_q[$];

  // Reference model state
  logic [11:0] m_q[$];
  bit          m_en, m_avg, m_thr_ie, m_ovf_ie, m_ovf;
  int          m_thresh;
  int          m_acc, m_acnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%08h expected=%08h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge pclk) begin
    if (psel && penable && !pwrite) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read actual=%08h expected=none", prdata);
      end else begin
        chk($sformatf("prdata_addr%0d", paddr), prdata, exp_q.pop_front());
      end
    end
  end

  function automatic logic [31:0] stat_exp();
    int lvl = m_q.size();
    bit thr = (m_thresh != 0) && (lvl >= m_thresh);
    return (32'(thr) << 11) | (32'(m_ovf) << 10) | (32'(lvl == DEPTH) << 9) |
           (32'(lvl == 0) << 8) | 32'(lvl);
  endfunction

  function automatic logic [31:0] ctrl_exp();
    return (32'(m_ovf_ie) << 9) | (32'(m_thr_ie) << 8) | (32'(m_thresh) << 4) |
           (32'(m_avg) << 2) | 32'(m_en);
  endfunction

  function automatic logic int_exp();
    bit thr = (m_thresh != 0) && (m_q.size() >= m_thresh);
    return (m_thr_ie && thr) || (m_ovf_ie && m_ovf);
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_en = 0; m_avg = 0; m_thr_ie = 0; m_ovf_ie = 0; m_ovf = 0;
    m_thresh = 0; m_acc = 0; m_acnt = 0;
  endfunction

  function automatic void model_push(input logic [11:0] v);
    if (m_q.size() < DEPTH) m_q.push_back(v);
    else m_ovf = 1;
  endfunction

  function automatic void model_sample(input logic [11:0] d);
    if (!m_en) return;
    if (m_avg) begin
      m_acc += d;
      m_acnt++;
      if (m_acnt == 4) begin
        model_push(12'((m_acc / 4) & 'hFFF));
        m_acc = 0;
        m_acnt = 0;
      end
    end else begin
      model_push(d);
    end
  endfunction

  task automatic apb_access(input logic wr, input logic [3:0] a, input logic [31:0] wd);
    @(posedge pclk); #1;
    psel = 1; penable = 1; pwrite = wr; paddr = a; pwdata = wd;
    @(posedge pclk); #1;
    psel = 0; penable = 0; pwrite = 0;
  endtask

  task automatic rd_reg(input logic [3:0] a, input logic [31:0] e);
    exp_q.push_back(e);
    apb_access(1'b0, a, 32'h0);
  endtask

  task automatic rd_data();
    if (m_q.size() > 0) exp_q.push_back({1'b1, 19'b0, m_q.pop_front()});
    else exp_q.push_back(32'h0);
    apb_access(1'b0, 4'h2, 32'h0);
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    bit new_avg;
    apb_access(1'b1, 4'h0, v);
`ifdef SADC_FIFO_AVG_EN
    new_avg = v[2];
`else
    new_avg = 0;
`endif
    if (v[1]) m_q.delete();
    if (v[1] || !v[0] || new_avg != m_avg) begin m_acc = 0; m_acnt = 0; end
    m_en = v[0]; m_avg = new_avg; m_thresh = int'(v[7:4]);
    m_thr_ie = v[8]; m_ovf_ie = v[9];
  endtask

  task automatic wr_stat(input logic [31:0] v);
    apb_access(1'b1, 4'h1, v);
    if (v[10]) m_ovf = 0;
  endtask

  task automatic strobe(input logic [11:0] d);
    @(posedge pclk); #1;
    fr_sadc_data = d;
    fr_sadc_clk = 1;
    repeat (3) @(posedge pclk);
    #1 fr_sadc_clk = 0;
    repeat (3) @(posedge pclk);
    model_sample(d);
  endtask

  task automatic chk_int();
    repeat (2) @(posedge pclk);
    #1 chk("sadc_int", {31'b0, sadc_int}, {31'b0, int_exp()});
  endtask

  initial begin
    model_reset();
    repeat (3) @(posedge pclk);
    #1 presetn = 1;

    // Reset state
    chk("int_reset", {31'b0, sadc_int}, 32'h0);
    chk("pready", {31'b0, pready}, 32'h1);
    rd_reg(4'h0, 32'h0);
    rd_reg(4'h1, 32'h100);
    rd_data();

    // Three known samples, then an empty read
    wr_ctrl(32'h1);
    strobe(12'h123); strobe(12'h456); strobe(12'h789);
    rd_reg(4'h1, stat_exp());
    rd_data(); rd_data(); rd_data(); rd_data();

    // Overflow with interrupt, then W1C
    wr_ctrl(32'h201);
    for (int i = 0; i < DEPTH + 1; i++) strobe(12'($urandom));
    rd_reg(4'h1, stat_exp());
    chk_int();
    wr_stat(32'h400);
    chk_int();
    rd_reg(4'h1, stat_exp());
    while (m_q.size() > 0) rd_data();

    // Threshold interrupt
    wr_ctrl(32'h141);
    for (int i = 0; i < 3; i++) strobe(12'($urandom));
    chk_int();
    strobe(12'($urandom));
    chk_int();
    rd_data();
    chk_int();
    while (m_q.size() > 0) rd_data();

    // Full FIFO: DATA read on the same cycle as the push
    wr_ctrl(32'h1);
    for (int i = 0; i < DEPTH; i++) strobe(12'($urandom));
    rd_reg(4'h1, stat_exp());
    begin
      logic [11:0] nd;
      nd = 12'($urandom);
      @(posedge pclk); #1;
      fr_sadc_data = nd;
      fr_sadc_clk = 1;
      @(posedge pclk);
      @(posedge pclk); #1;
      exp_q.push_back({1'b1, 19'b0, m_q.pop_front()});
      psel = 1; penable = 1; pwrite = 0; paddr = 4'h2;
      @(posedge pclk); #1;
      psel = 0; penable = 0;
      @(posedge pclk); #1;
      fr_sadc_clk = 0;
      repeat (3) @(posedge pclk);
      model_push(nd);
    end
    rd_reg(4'h1, stat_exp());
    while (m_q.size() > 0) rd_data();

    // Flush keeps ovf
    for (int i = 0; i < DEPTH + 1; i++) strobe(12'($urandom));
    for (int i = 0; i < DEPTH - 5; i++) rd_data();
    rd_reg(4'h1, stat_exp());
    wr_ctrl(32'h3);
    rd_reg(4'h1, stat_exp());
    wr_stat(32'h400);

    // Disabled capture keeps contents
    strobe(12'h0AA); strobe(12'h0BB);
    wr_ctrl(32'h0);
    for (int i = 0; i < 3; i++) strobe(12'($urandom));
    rd_reg(4'h1, stat_exp());
    rd_data(); rd_data(); rd_data();

    // CTRL field mask and averaging
    wr_ctrl(32'hFFFF_F3F5);
    rd_reg(4'h0, ctrl_exp());
    wr_ctrl(32'h5);
    rd_reg(4'h0, ctrl_exp());
    strobe(12'h100); strobe(12'h200); strobe(12'h300); strobe(12'h401);
    rd_reg(4'h1, stat_exp());
    while (m_q.size() > 0) rd_data();

    // Randomized mix
    wr_ctrl(32'h1);
    for (int n = 0; n < 200; n++) begin
      int op;
      op = int'($urandom_range(0, 11));
      if (op <= 4) strobe(12'($urandom));
      else if (op <= 7) rd_data();
      else if (op == 8) rd_reg(4'h1, stat_exp());
      else if (op == 9) chk_int();
      else if (op == 10) begin
        logic [31:0] v;
        v = ($urandom & 32'h3F5) | 32'h1;
        v[1] = ($urandom_range(0, 7) == 0);
        wr_ctrl(v);
      end else wr_stat($urandom & 32'h400);
    end
    rd_reg(4'h0, ctrl_exp());
    while (m_q.size() > 0) rd_data();

    // Reset in the middle of a stream
    wr_ctrl(32'h301);
    for (int i = 0; i < 3; i++) strobe(12'($urandom));
    @(posedge pclk); #1 presetn = 0;
    model_reset();
    rd_reg(4'h0, 32'h0);
    rd_reg(4'h1, 32'h0);
    rd_data();
    #1 chk("int_in_reset", {31'b0, sadc_int}, 32'h0);
    @(posedge pclk); #1 presetn = 1;
    rd_reg(4'h1, 32'h100);
    rd_reg(4'h0, 32'h0);
    rd_data();
    chk_int();

    repeat (2) @(posedge pclk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1);
  end

endmodule
